// File: rtl/wb_sram_ctrl_pkg.sv
// Shared types and default geometry for the Wishbone-to-SRAM bridge.
package sram_ctrl_pkg;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_WMASKS = DEF_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_e;

endpackage

// File: rtl/wb_sram_ctrl.sv
// Wishbone classic slave fronting a single-port synchronous SRAM macro.
// Fixed 4-cycle access: request registered, sampled by SRAM, data captured, ack.
//
// state | meaning
// IDLE  | waiting for an address hit; request fields registered on hit
// ISSUE | csb0 low, SRAM samples the request on the next edge
// WAIT  | SRAM read data valid; ack raised unless cycle was abandoned
// ACK   | ack pulse visible; return to IDLE before accepting the next hit
module wb_sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int          DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int          NUM_WMASKS = DEF_NUM_WMASKS
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_we_i,
  input  logic [NUM_WMASKS-1:0] wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [DATA_WIDTH-1:0] wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [DATA_WIDTH-1:0] wbs_dat_o,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  state_e                state_q, state_d;
  logic                  csb_q, csb_d;
  logic                  web_q, web_d;
  logic [NUM_WMASKS-1:0] wmask_q, wmask_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  ack_q, ack_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic                  wr_q, wr_d;
  logic                  abort_q, abort_d;
  logic                  hit;

  // Byte-lane offset bits never select anything in a word-wide SRAM.
  logic unused_adr_lsb;
  assign unused_adr_lsb = &{1'b0, wbs_adr_i[1:0]};

  assign hit = wbs_cyc_i & wbs_stb_i &
               (wbs_adr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);

  always_comb begin
    state_d = state_q;
    csb_d   = 1'b1;
    web_d   = 1'b1;
    wmask_d = wmask_q;
    addr_d  = addr_q;
    din_d   = din_q;
    ack_d   = 1'b0;
    dat_d   = dat_q;
    wr_d    = wr_q;
    abort_d = abort_q;
    case (state_q)
      ST_IDLE: begin
        if (hit) begin
          state_d = ST_ISSUE;
          csb_d   = 1'b0;
          web_d   = ~wbs_we_i;
          addr_d  = wbs_adr_i[ADDR_WIDTH+1:2];
          din_d   = wbs_dat_i;
          wmask_d = wbs_we_i ? wbs_sel_i : '0;
          wr_d    = wbs_we_i;
          abort_d = 1'b0;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        if (!wbs_cyc_i) abort_d = 1'b1;
      end
      ST_WAIT: begin
        state_d = ST_ACK;
        ack_d   = wbs_cyc_i & ~abort_q;
        if (!wr_q) dat_d = sram_dout0;
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      csb_q   <= 1'b1;
      web_q   <= 1'b1;
      wmask_q <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      wr_q    <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      csb_q   <= csb_d;
      web_q   <= web_d;
      wmask_q <= wmask_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      wr_q    <= wr_d;
      abort_q <= abort_d;
    end
  end

  assign sram_csb0   = csb_q;
  assign sram_web0   = web_q;
  assign sram_wmask0 = wmask_q;
  assign sram_addr0  = addr_q;
  assign sram_din0   = din_q;
  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = dat_q;

endmodule

// File: tb/tb_wb_sram_ctrl.sv
// Directed bench for wb_sram_ctrl with a behavioural 32x256 byte-masked SRAM.
module tb_wb_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat;
  logic        ack;
  logic [31:0] dat_o;
  logic        csb0, web0;
  logic [3:0]  wmask0;
  logic [7:0]  addr0;
  logic [31:0] din0;
  logic [31:0] dout0;

  logic [31:0] mem [256];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_sram_ctrl dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wbs_cyc_i  (cyc),
    .wbs_stb_i  (stb),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (dat),
    .wbs_ack_o  (ack),
    .wbs_dat_o  (dat_o),
    .sram_csb0  (csb0),
    .sram_web0  (web0),
    .sram_wmask0(wmask0),
    .sram_addr0 (addr0),
    .sram_din0  (din0),
    .sram_dout0 (dout0)
  );

  always @(posedge clk) begin
    if (!csb0) begin
      if (!web0) begin
        for (int b = 0; b < 4; b++)
          if (wmask0[b]) mem[addr0][b*8 +: 8] <= din0[b*8 +: 8];
      end else begin
        dout0 <= mem[addr0];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output int lat, output int lows,
                           output logic [7:0] a0, output logic w0, output logic [3:0] m0,
                           output logic [31:0] rd);
    lat = 0; lows = 0; a0 = '0; w0 = 1'b1; m0 = '0; rd = '0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (!csb0) begin
        lows++; a0 = addr0; w0 = web0; m0 = wmask0;
      end
      if (ack) begin
        lat = e; rd = dat_o;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        hit;
    logic [7:0]  a0;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int          lat, lows, n_ack, n_low;
    logic [7:0]  a0;
    logic        w0;
    logic [3:0]  m0;
    logic [31:0] rd;

    for (int i = 0; i < 256; i++) mem[i] = '0;
    dout0 = '0;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; dat = '0;

    vecs[0]  = '{1'b1, 32'h3000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1, 8'h04, 32'h0000_0000};
    vecs[1]  = '{1'b0, 32'h3000_0010, 32'h0,         4'hF, 1'b1, 8'h04, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 32'h3000_0000, 32'h1122_3344, 4'hF, 1'b1, 8'h00, 32'hDEAD_BEEF};
    vecs[3]  = '{1'b1, 32'h3000_0000, 32'hAABB_CCDD, 4'h5, 1'b1, 8'h00, 32'hDEAD_BEEF};
    vecs[4]  = '{1'b0, 32'h3000_0000, 32'h0,         4'hF, 1'b1, 8'h00, 32'h11BB_33DD};
    vecs[5]  = '{1'b1, 32'h3000_0400, 32'h5555_5555, 4'hF, 1'b0, 8'h00, 32'h0};
    vecs[6]  = '{1'b0, 32'h2000_0000, 32'h0,         4'hF, 1'b0, 8'h00, 32'h0};
    vecs[7]  = '{1'b1, 32'h3000_03FC, 32'hCAFE_F00D, 4'hF, 1'b1, 8'hFF, 32'h11BB_33DD};
    vecs[8]  = '{1'b0, 32'h3000_03FC, 32'h0,         4'hF, 1'b1, 8'hFF, 32'hCAFE_F00D};
    vecs[9]  = '{1'b1, 32'h3000_0010, 32'h0,         4'h0, 1'b1, 8'h04, 32'hCAFE_F00D};
    vecs[10] = '{1'b0, 32'h3000_0010, 32'h0,         4'hF, 1'b1, 8'h04, 32'hDEAD_BEEF};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_csb0", {31'b0, csb0}, 32'h1);
    chk("rst_web0", {31'b0, web0}, 32'h1);
    chk("rst_wmask0", {28'b0, wmask0}, 32'h0);
    chk("rst_addr0", {24'b0, addr0}, 32'h0);
    chk("rst_din0", din0, 32'h0);
    chk("rst_ack", {31'b0, ack}, 32'h0);
    chk("rst_dat_o", dat_o, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      do_access(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, lat, lows, a0, w0, m0, rd);
      if (vecs[i].hit) begin
        chk($sformatf("v%0d_latency", i), lat, 3);
        chk($sformatf("v%0d_csb_lows", i), lows, 1);
        chk($sformatf("v%0d_addr0", i), {24'b0, a0}, {24'b0, vecs[i].a0});
        chk($sformatf("v%0d_web0", i), {31'b0, w0}, {31'b0, ~vecs[i].we});
        chk($sformatf("v%0d_wmask0", i), {28'b0, m0}, vecs[i].we ? {28'b0, vecs[i].sel} : 32'h0);
        chk($sformatf("v%0d_dat_o", i), rd, vecs[i].rd);
        chk($sformatf("v%0d_addr0_hold", i), {24'b0, addr0}, {24'b0, vecs[i].a0});
      end else begin
        chk($sformatf("v%0d_miss_ack", i), lat, 0);
        chk($sformatf("v%0d_miss_csb", i), lows, 0);
      end
    end

    // Master abandons the cycle while the FSM is in WAIT.
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0000; sel = 4'hF;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    n_ack = 0;
    repeat (4) begin
      @(posedge clk); @(negedge clk);
      if (ack) n_ack++;
    end
    chk("abort_no_ack", n_ack, 0);
    do_access(1'b0, 32'h3000_03FC, 32'h0, 4'hF, lat, lows, a0, w0, m0, rd);
    chk("after_abort_latency", lat, 3);
    chk("after_abort_data", rd, 32'hCAFE_F00D);

    // Request held across acks: one access per 4 cycles, no early re-issue.
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0010; sel = 4'hF;
    n_ack = 0; n_low = 0;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk); @(negedge clk);
      if (!csb0) n_low++;
      if (ack) begin
        n_ack++;
        chk($sformatf("b2b_ack_edge_e%0d", e), e % 4, 3);
      end
    end
    cyc = 1'b0; stb = 1'b0;
    chk("b2b_csb_lows", n_low, 2);
    chk("b2b_acks", n_ack, 2);
    repeat (4) @(posedge clk);

    // Reset asserted while the FSM is in ISSUE.
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_0020; dat = 32'h1234_5678; sel = 4'hF;
    @(posedge clk); @(negedge clk);
    chk("issue_csb0_low", {31'b0, csb0}, 32'h0);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    chk("midrst_csb0", {31'b0, csb0}, 32'h1);
    chk("midrst_web0", {31'b0, web0}, 32'h1);
    chk("midrst_wmask0", {28'b0, wmask0}, 32'h0);
    chk("midrst_addr0", {24'b0, addr0}, 32'h0);
    chk("midrst_din0", din0, 32'h0);
    chk("midrst_ack", {31'b0, ack}, 32'h0);
    chk("midrst_dat_o", dat_o, 32'h0);
    n_ack = 0; n_low = 0;
    repeat (6) begin
      @(posedge clk); @(negedge clk);
      if (ack) n_ack++;
      if (!csb0) n_low++;
    end
    chk("midrst_no_ack", n_ack, 0);
    chk("midrst_no_csb", n_low, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/wb_sram_ctrl.md
WB_SRAM_CTRL -- requirements
Module: wb_sram_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, Wishbone byte address of SRAM word 0.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, SRAM word-address width (256 words).
REQ-003 SHALL have parameter DATA_WIDTH, default 32, data width.
REQ-004 SHALL have parameter NUM_WMASKS, default 4, byte-lane count (DATA_WIDTH/8).
REQ-005 SHALL have port wb_clk_i  in  1  single clock; the SRAM clk0 is tied to this net at top level.
REQ-006 SHALL have port wb_rst_i  in  1  reset, synchronous, active-high.
REQ-007 SHALL have ports wbs_cyc_i/wbs_stb_i/wbs_we_i  in  1 each  Wishbone classic cycle, strobe, write enable.
REQ-008 SHALL have ports wbs_sel_i  in  4  byte selects; wbs_adr_i  in  32  byte address; wbs_dat_i  in  32  write data.
REQ-009 SHALL have ports wbs_ack_o  out  1  acknowledge; wbs_dat_o  out  32  read data.
REQ-010 SHALL have ports sram_csb0  out  1  active-low chip select; sram_web0  out  1  active-low write enable.
REQ-011 SHALL have ports sram_wmask0  out  4;  sram_addr0  out  8;  sram_din0  out  32  -- SRAM request fields.
REQ-012 SHALL have port sram_dout0  in  32  SRAM read data.

Function
REQ-013 All outputs SHALL be registered on posedge wb_clk_i.
REQ-014 Hit SHALL be wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]); misses SHALL be ignored (no ack, no SRAM access).
REQ-015 FSM states SHALL be IDLE, ISSUE, WAIT, ACK; reset state IDLE.
REQ-016 IDLE: on hit at edge T0 -> ISSUE; register sram_csb0=0, sram_web0=~wbs_we_i, sram_addr0=wbs_adr_i[ADDR_WIDTH+1:2], sram_din0=wbs_dat_i, sram_wmask0 = we ? wbs_sel_i : 0.
REQ-017 ISSUE: at T1 (SRAM samples request) -> WAIT; sram_csb0=1, sram_web0=1; sram_csb0 low for exactly one cycle per access.
REQ-018 WAIT: at T2 -> ACK; wbs_ack_o=1 if wbs_cyc_i still high; reads load wbs_dat_o=sram_dout0, writes leave wbs_dat_o unchanged.
REQ-019 ACK: at T3 -> IDLE; wbs_ack_o=0; ack SHALL be a one-cycle pulse, read latency T0->ack = 3 edges, 4 cycles per access.
REQ-020 A hit present in ACK or IDLE-after-ACK SHALL NOT re-issue until the IDLE state is entered; back-to-back throughput one access per 4 cycles.
REQ-021 wbs_cyc_i dropping in ISSUE/WAIT SHALL let the SRAM access complete but SHALL suppress ack.
REQ-022 Request fields SHALL be held stable (except csb0/web0) from T0 until next issue.
REQ-023 wbs_sel_i=0 write SHALL still perform the cycle with wmask0=0 and ack.

Reset
REQ-024 wb_rst_i high at a posedge SHALL force: state IDLE, sram_csb0=1, sram_web0=1, sram_wmask0=0, sram_addr0=0, sram_din0=0, wbs_ack_o=0, wbs_dat_o=0.
REQ-025 Reset mid-access SHALL abort it: no ack; csb0=1 on the following cycle (a write already sampled by the SRAM may complete).

Structure
REQ-026 Package sram_ctrl_pkg SHALL hold the state enum and ADDR_WIDTH/DATA_WIDTH/NUM_WMASKS defaults.
REQ-027 Single module; no sub-module required.

Verification (bench pairs with the behavioural 32x256 SRAM model)
REQ-028 Write adr 32'h3000_0010, dat 32'hDEAD_BEEF, sel 4'hF -> one csb0 low cycle, web0=0, addr0=8'h04, ack 3 edges after request; readback returns 32'hDEAD_BEEF.
REQ-029 Write 32'h1122_3344 to adr 0 sel 4'hF, then 32'hAABB_CCDD sel 4'b0101 -> read adr 0 returns 32'h11BB_33DD.
REQ-030 Access at 32'h3000_0400 and 32'h2000_0000 -> no csb0 low, no ack (bench timeout 20 cycles).
REQ-031 Read adr 32'h3000_03FC after writing 32'hCAFE_F00D -> addr0=8'hFF, wbs_dat_o=32'hCAFE_F00D with ack.
REQ-032 Deassert wbs_cyc_i in WAIT -> no ack, FSM back in IDLE, next read succeeds; assert wb_rst_i in ISSUE -> csb0=1, ack=0, all outputs at reset values next cycle.
